hash_drbg_core: RTL and testbench

//  SHA-256 based deterministic random bit generator (simplified Hash_DRBG) for the scrambler key stream.

---
 rtl/hash_drbg_pkg.sv | 14 +
 rtl/hash_drbg_core.sv | 125 ++++++++++++
 tb/tb_hash_drbg_core.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/hash_drbg_pkg.sv
// Shared types and block-padding helper for the Hash_DRBG controller.
package hash_drbg_pkg;

  typedef enum logic [2:0] {IDLE, SHA_RST, SHA_WAIT_RDY, SHA_BUSY, COMMIT} state_e;
  typedef enum logic [1:0] {OP_INST, OP_RESEED, OP_GEN} op_e;

  // Single-block SHA-256 padding for a fixed 256-bit message
  localparam logic [255:0] SHA_PAD_256 = {1'b1, 191'b0, 64'd256};

  function automatic logic [511:0] pack_block(input logic [255:0] msg);
    return {msg, SHA_PAD_256};
  endfunction

endpackage

// File: rtl/hash_drbg_core.sv
// Simplified Hash_DRBG: sequences an external sha256_core to seed, reseed and
// generate 256-bit words from internal state V.
module hash_drbg_core
  import hash_drbg_pkg::*;
#(
  parameter int RESEED_INTERVAL = 1024,
  parameter int CTR_W           = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] entropy,
  input  logic         update,
  input  logic         next,
  output logic         init_ready,
  output logic         next_ready,
  output logic         do_reseed,
  output logic [255:0] random_bits,
  output logic         sha_init,
  output logic         sha_reset_n,
  output logic [511:0] sha_block,
  input  logic         sha_ready,
  input  logic [255:0] sha_digest,
  input  logic         sha_digest_valid
);

  localparam logic [CTR_W-1:0] RI = CTR_W'(RESEED_INTERVAL);

  state_e           state, state_nx;
  op_e              op_q, start_op;
  logic [255:0]     v_q, h_q, msg;
  logic [CTR_W-1:0] ctr, ctr_inc;
  logic             upd_q, upd_pend, upd_rise, upd_evt;
  logic             init_d, start, dig_take;

  assign upd_rise = update & ~upd_q;
  assign upd_evt  = upd_pend | upd_rise;
  assign ctr_inc  = (&ctr) ? ctr : ctr + 1'b1;
  // The core may still show the previous digest right after sha_init
  assign dig_take = sha_digest_valid & ~sha_init & ~init_d;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    start_op = OP_GEN;
    msg      = v_q;
    case (state)
      IDLE: begin
        if (upd_evt) begin
          start    = 1'b1;
          start_op = init_ready ? OP_RESEED : OP_INST;
          msg      = init_ready ? (v_q ^ entropy) : entropy;
        end else if (next && init_ready) begin
          start    = 1'b1;
          start_op = OP_GEN;
        end
        if (start) state_nx = SHA_RST;
      end
      SHA_RST:      state_nx = SHA_WAIT_RDY;
      SHA_WAIT_RDY: if (sha_ready) state_nx = SHA_BUSY;
      SHA_BUSY:     if (dig_take) state_nx = COMMIT;
      COMMIT:       state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q         <= '0;
      h_q         <= '0;
      ctr         <= '0;
      op_q        <= OP_INST;
      random_bits <= '0;
      init_ready  <= 1'b0;
      next_ready  <= 1'b0;
      do_reseed   <= 1'b0;
      sha_init    <= 1'b0;
      sha_reset_n <= 1'b0;
      sha_block   <= '0;
      upd_q       <= 1'b0;
      upd_pend    <= 1'b0;
      init_d      <= 1'b0;
    end else begin
      upd_q       <= update;
      // Every update event seen in IDLE is accepted there; otherwise hold it
      upd_pend    <= (state == IDLE) ? 1'b0 : (upd_pend | upd_rise);
      sha_reset_n <= (state_nx != SHA_RST);
      sha_init    <= (state == SHA_WAIT_RDY) && sha_ready;
      init_d      <= sha_init;
      if (start) begin
        op_q      <= start_op;
        sha_block <= pack_block(msg);
        if (start_op == OP_GEN) next_ready <= 1'b0;
      end
      if (state == SHA_BUSY && dig_take) h_q <= sha_digest;
      if (state == COMMIT) begin
        case (op_q)
          OP_INST: begin
            v_q        <= h_q;
            ctr        <= '0;
            do_reseed  <= 1'b0;
            init_ready <= 1'b1;
          end
          OP_RESEED: begin
            v_q       <= h_q;
            ctr       <= '0;
            do_reseed <= 1'b0;
          end
          default: begin
            random_bits <= h_q;
            v_q         <= v_q + h_q + 256'(ctr);
            ctr         <= ctr_inc;
            do_reseed   <= (ctr_inc >= RI);
            next_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hash_drbg_core.sv
// Bench for hash_drbg_core: behavioural SHA-256 core plus directed DRBG sequences.
module tb_hash_drbg_core;

  localparam int LAT = 12;

  logic         clk = 1'b0;
  logic         reset_n, update, next;
  logic [255:0] entropy;
  logic         init_ready, next_ready, do_reseed;
  logic [255:0] random_bits;
  logic         sha_init, sha_reset_n;
  logic [511:0] sha_block;
  logic         sha_ready, sha_digest_valid;
  logic [255:0] sha_digest;

  int errs = 0, checks = 0, init_cnt = 0;

  localparam logic [255:0] ZERO_HASH =
    256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
           + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3]; e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + H0[0], b + H0[1], c + H0[2], d + H0[3], e + H0[4], f + H0[5], g + H0[6], h + H0[7]};
  endfunction

  function automatic logic [255:0] hmsg(input logic [255:0] m);
    return sha256_blk({m, 1'b1, 191'b0, 64'd256});
  endfunction

  hash_drbg_core #(.RESEED_INTERVAL(4), .CTR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .entropy(entropy), .update(update), .next(next),
    .init_ready(init_ready), .next_ready(next_ready), .do_reseed(do_reseed),
    .random_bits(random_bits), .sha_init(sha_init), .sha_reset_n(sha_reset_n),
    .sha_block(sha_block), .sha_ready(sha_ready), .sha_digest(sha_digest),
    .sha_digest_valid(sha_digest_valid));

  always #5 clk = ~clk;

  // Behavioural single-block sha256_core with fixed latency
  int cnt;
  always @(posedge clk) begin
    if (!reset_n || !sha_reset_n) begin
      sha_ready <= 1'b1; sha_digest_valid <= 1'b0; sha_digest <= '0; cnt <= 0;
    end else if (sha_init) begin
      sha_ready <= 1'b0; sha_digest_valid <= 1'b0; cnt <= LAT;
      sha_digest <= sha256_blk(sha_block);
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin sha_ready <= 1'b1; sha_digest_valid <= 1'b1; end
    end
  end

  always @(posedge clk) if (sha_init === 1'b1) init_cnt++;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a next_ready rising edge, sampled on falling edges
  task automatic wait_nr_rise(input string tag);
    logic prev;
    prev = next_ready;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (next_ready && !prev) return;
      prev = next_ready;
    end
    chk({tag, "_timeout"}, 256'd0, 256'd1);
  endtask

  logic [255:0] mv, exp_rb, prev_rb;
  int unsigned  mctr;

  task automatic model_gen();
    logic [255:0] h;
    h      = hmsg(mv);
    exp_rb = h;
    mv     = mv + h + 256'(mctr);
    mctr++;
  endtask

  initial begin
    reset_n = 1'b0; update = 1'b0; next = 1'b1; entropy = '0;
    // 1: reset holds everything at zero even with next high
    cyc(10);
    chk("rst_init_ready", 256'(init_ready), 256'd0);
    chk("rst_next_ready", 256'(next_ready), 256'd0);
    chk("rst_do_reseed", 256'(do_reseed), 256'd0);
    chk("rst_random_bits", random_bits, 256'd0);
    chk("rst_sha_reset_n", 256'(sha_reset_n), 256'd0);
    chk("rst_sha_init", 256'(sha_init), 256'd0);
    reset_n = 1'b1;
    cyc(20);
    chk("next_ignored_unseeded", 256'(init_cnt), 256'd0);
    next = 1'b0;

    // 2: instantiate from all-zero entropy
    update = 1'b1; cyc(2); update = 1'b0;
    for (int i = 0; i < 100 && !init_ready; i++) cyc(1);
    chk("inst_init_ready", 256'(init_ready), 256'd1);
    chk("inst_v", dut.v_q, ZERO_HASH);
    chk("inst_next_ready", 256'(next_ready), 256'd0);
    mv = ZERO_HASH; mctr = 0; prev_rb = '0;

    // 3/4: back-to-back generations; do_reseed flags after the 4th
    next = 1'b1;
    for (int g = 0; g < 11; g++) begin
      wait_nr_rise("gen");
      if (g == 10) next = 1'b0;
      model_gen();
      chk($sformatf("gen%0d_bits", g), random_bits, exp_rb);
      chk($sformatf("gen%0d_distinct", g), 256'(random_bits != prev_rb), 256'd1);
      chk($sformatf("gen%0d_do_reseed", g), 256'(do_reseed), 256'(mctr >= 4));
      prev_rb = random_bits;
    end
    cyc(30);
    chk("no_extra_gen", random_bits, exp_rb);

    entropy = 256'hdeadbeef_01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_a5a5a5a5;
    update = 1'b1; cyc(2); update = 1'b0;
    cyc(40);
    mv = hmsg(mv ^ entropy); mctr = 0;
    chk("reseed_do_reseed", 256'(do_reseed), 256'd0);
    chk("reseed_v", dut.v_q, mv);

    // 5: update arrives mid-generation; gen finishes, then reseed, then next waits
    next = 1'b1; cyc(2); next = 1'b0;
    chk("gen_accept_nr_low", 256'(next_ready), 256'd0);
    cyc(3);
    entropy = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
    update = 1'b1; cyc(2); update = 1'b0; next = 1'b1;
    wait_nr_rise("mid_gen");
    model_gen();
    chk("mid_gen_bits", random_bits, exp_rb);
    mv = hmsg(mv ^ entropy); mctr = 0;
    wait_nr_rise("after_reseed");
    next = 1'b0;
    model_gen();
    chk("after_reseed_bits", random_bits, exp_rb);
    chk("after_reseed_do_reseed", 256'(do_reseed), 256'd0);

    // 6: reset mid-hash, then reinstantiate
    cyc(5);
    next = 1'b1; cyc(6);
    reset_n = 1'b0; next = 1'b0;
    cyc(1);
    chk("abort_init_ready", 256'(init_ready), 256'd0);
    chk("abort_next_ready", 256'(next_ready), 256'd0);
    chk("abort_random_bits", random_bits, 256'd0);
    chk("abort_sha_reset_n", 256'(sha_reset_n), 256'd0);
    chk("abort_sha_init", 256'(sha_init), 256'd0);
    reset_n = 1'b1; cyc(2);
    entropy = 256'h0123456789abcdef_0123456789abcdef_0123456789abcdef_0123456789abcdef;
    update = 1'b1; cyc(2); update = 1'b0;
    for (int i = 0; i < 100 && !init_ready; i++) cyc(1);
    mv = hmsg(entropy); mctr = 0;
    chk("reinst_init_ready", 256'(init_ready), 256'd1);
    chk("reinst_v", dut.v_q, mv);
    next = 1'b1;
    wait_nr_rise("reinst_gen");
    next = 1'b0;
    model_gen();
    chk("reinst_gen_bits", random_bits, exp_rb);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
